riscv_soc_top: RTL and testbench
================================

# riscv_soc_top

Minimal RV32I SoC top level: a UART receiver that downloads a program into on-chip instruction memory, plus a single-cycle integer core that fetches from that memory and executes it. The host streams instruction words over `uart_rx`, then pulses reset to start execution at address 0. Program RAM contents survive reset; all other state is cleared.

## Interface

Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: UART bit rate. `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer division, 5208 at defaults).
- `IMEM_DEPTH`, 256: instruction memory depth in 32-bit words (power of two).

Ports:
- `clk`, in, 1: single system clock, rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `uart_rx`, in, 1: UART receive line, 8N1, LSB first, idle high.
- `uart_tx`, out, 1: UART transmit line. Reserved; driven constant 1 (idle).

## Operation

- **UART receive.**
  - `uart_rx` passes through a 2-flop synchronizer.
  - FSM states: IDLE, START, DATA, STOP.
  - IDLE to START on a synchronized falling edge.
  - START samples at `CLKS_PER_BIT/2`. If the line is high, return to IDLE (glitch); otherwise go to DATA.
  - DATA samples 8 bits, each `CLKS_PER_BIT` apart, LSB first.
  - STOP samples once more. The byte is accepted only if the stop bit is 1; otherwise it is discarded. Then return to IDLE.
- **Word assembly.**
  - Bytes arrive most-significant first: `word = {word[23:0], byte}`.
  - A 2-bit byte counter tracks position. On the 4th accepted byte, write the word to `imem[wr_ptr]` and increment `wr_ptr`, wrapping modulo `IMEM_DEPTH`.
- **Instruction memory.**
  - `IMEM_DEPTH` x 32 array with asynchronous read and synchronous write.
  - Contents are initialised to 0 at configuration and are not affected by `rst_n`.
  - Fetch index is `pc[log2(IMEM_DEPTH)+1:2]`.
- **Core.**
  - Single-cycle: fetch, decode, execute and writeback all complete in one clock.
  - Register file: 32 x 32, `x0` hardwired to 0, two async read ports, one sync write port. Registers are reset to 0.
- **Supported instructions.**
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - LUI, AUIPC.
  - JAL, JALR (write `pc+4` to rd; JALR target has bit 0 cleared).
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
- **Unsupported encodings.** Every other encoding executes as a NOP with `pc+4`. This includes loads, stores, FENCE, SYSTEM and all-zero words.
- **Arithmetic.**
  - All arithmetic is 32-bit, wrap-around, with no exceptions.
  - Shifts use bits [4:0] of the amount.
  - Immediates are sign-extended per the RV32I I/S/B/U/J formats.
  - Branch and JAL targets are `pc + imm`. Misaligned targets are not trapped; the low 2 bits are ignored by fetch.

## Timing

- **Reset values:** `pc = 0`, all registers = 0, `wr_ptr = 0`, byte counter = 0, UART FSM = IDLE, `uart_tx = 1`.
- **Reset mid-operation:** any partial byte or word is discarded.
- **Core:** one instruction retires per clock from the first rising edge after `rst_n` deasserts. `pc` and rd update on the same edge.
- **Download vs. execution:** the core runs continuously, including during a download. The host is required to reset the SoC after a download to restart from address 0.
- **Download latency:** the IMEM write occurs on the clock after the 4th stop-bit sample. The word is fetchable on the following cycle.
- **Simultaneous events:** an IMEM write and a fetch of the same address in the same cycle returns the old word.

## Structure

- **Shared package `riscv_pkg`:** opcode constants, funct3/funct7 constants, ALU-operation enum, and a `clks_per_bit` function.
- **Sub-modules:**
  - `uart_rx`: outputs `byte_valid` pulse and `byte_data`.
  - Core datapath (`riscv_core`), including regfile, decode and ALU.
  - The top level holds the word assembler and IMEM.

## Test plan

- **Download and run.**
  - Stimulus: send bytes 00 10 00 93, 00 20 01 13, 00 10 80 B3, FE 20 8E E3 at 9600 baud, then pulse `rst_n` low.
  - Required: `imem[0..3]` = 0x00100093, 0x00200113, 0x001080B3, 0xFE208EE3.
  - Required after release: PC sequence is 0, 4, 8, 0xC, 8, 0xC, 0x10, then continues +4 through NOPs.
  - Required final state: `x1 = 4`, `x2 = 2`.
- **Framing error.** Send a byte with stop bit 0 → byte dropped; byte counter unchanged. The next four good bytes form one word.
- **Start glitch.** A 1000-clock low pulse on `uart_rx` → no byte accepted; FSM back in IDLE.
- **Reset mid-word.** Send 2 bytes, reset, then send 4 bytes → those 4 bytes are written at address 0; IMEM contents written before reset are unchanged.
- **ALU and branch coverage.**
  - Program: `addi x3,x0,-1`; `srli x4,x3,28`; `srai x5,x3,28`; `sltu x6,x0,x3`; `bltu x3,x0,+8`.
  - Required: `x4 = 0xF`, `x5 = 0xFFFFFFFF`, `x6 = 1`, branch not taken.
- **x0 and JAL.** `jal x0,+8` and `addi x0,x0,5` → `x0` stays 0; PC jumps from 0 to 8.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I SoC: opcodes, funct fields, ALU operations
// and the UART bit-period helper.
package riscv_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_t;

    // Clocks per UART bit, truncated.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/riscv_soc_if.sv
// Byte link between the UART receiver and the program loader.
interface riscv_soc_if;
    logic       uart_rx;
    logic       byte_valid;
    logic [7:0] byte_data;

    modport master (input uart_rx, output byte_valid, output byte_data);
    modport slave  (input byte_valid, input byte_data);
endinterface

// File: rtl/riscv_core.sv
// Single-cycle RV32I integer core (no loads/stores/system); fetch from an
// external async-read memory by word index.
module riscv_core
    import riscv_pkg::*;
#(
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        i_instr,
    output logic [IMEM_AW-1:0] o_fetch_idx
);
    logic [31:0] r_pc;
    logic [31:0] r_regs [32];

    logic [6:0]  w_opcode, w_f7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_rs1_val, w_rs2_val, w_pc_plus4;
    logic [31:0] w_alu_a, w_alu_b, w_alu_y, w_wd, w_next_pc;
    alu_op_t     w_alu_op;
    logic        w_we, w_link, w_take;
    logic        w_eq, w_lt, w_ltu;

    assign w_opcode   = i_instr[6:0];
    assign w_rd       = i_instr[11:7];
    assign w_f3       = i_instr[14:12];
    assign w_rs1      = i_instr[19:15];
    assign w_rs2      = i_instr[24:20];
    assign w_f7       = i_instr[31:25];
    assign w_imm_i    = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_b    = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u    = {i_instr[31:12], 12'd0};
    assign w_imm_j    = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};

    // x0 is never written, so its reset value of zero persists.
    assign w_rs1_val  = r_regs[w_rs1];
    assign w_rs2_val  = r_regs[w_rs2];
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_eq       = (w_rs1_val == w_rs2_val);
    assign w_lt       = ($signed(w_rs1_val) < $signed(w_rs2_val));
    assign w_ltu      = (w_rs1_val < w_rs2_val);
    assign w_wd       = w_link ? w_pc_plus4 : w_alu_y;
    assign o_fetch_idx = r_pc[IMEM_AW+1:2];

    // Decode: pick ALU operands/op, writeback enable and next PC.
    always_comb begin
        w_alu_op  = ALU_ADD;
        w_alu_a   = w_rs1_val;
        w_alu_b   = w_rs2_val;
        w_we      = 1'b0;
        w_link    = 1'b0;
        w_take    = 1'b0;
        w_next_pc = w_pc_plus4;
        case (w_opcode)
            OPC_OP_IMM: begin
                w_alu_b = w_imm_i;
                w_we    = 1'b1;
                case (w_f3)
                    F3_ADD:  w_alu_op = ALU_ADD;
                    F3_SLT:  w_alu_op = ALU_SLT;
                    F3_SLTU: w_alu_op = ALU_SLTU;
                    F3_XOR:  w_alu_op = ALU_XOR;
                    F3_OR:   w_alu_op = ALU_OR;
                    F3_AND:  w_alu_op = ALU_AND;
                    F3_SLL: begin
                        if (w_f7 == F7_BASE) w_alu_op = ALU_SLL;
                        else                 w_we     = 1'b0;
                    end
                    F3_SR: begin
                        if (w_f7 == F7_BASE)     w_alu_op = ALU_SRL;
                        else if (w_f7 == F7_ALT) w_alu_op = ALU_SRA;
                        else                     w_we     = 1'b0;
                    end
                    default: w_we = 1'b0;
                endcase
            end
            OPC_OP: begin
                w_we = 1'b1;
                if (w_f7 == F7_BASE) begin
                    case (w_f3)
                        F3_ADD:  w_alu_op = ALU_ADD;
                        F3_SLL:  w_alu_op = ALU_SLL;
                        F3_SLT:  w_alu_op = ALU_SLT;
                        F3_SLTU: w_alu_op = ALU_SLTU;
                        F3_XOR:  w_alu_op = ALU_XOR;
                        F3_SR:   w_alu_op = ALU_SRL;
                        F3_OR:   w_alu_op = ALU_OR;
                        F3_AND:  w_alu_op = ALU_AND;
                        default: w_we     = 1'b0;
                    endcase
                end else if (w_f7 == F7_ALT && w_f3 == F3_ADD) begin
                    w_alu_op = ALU_SUB;
                end else if (w_f7 == F7_ALT && w_f3 == F3_SR) begin
                    w_alu_op = ALU_SRA;
                end else begin
                    w_we = 1'b0;
                end
            end
            OPC_LUI: begin
                w_alu_a = '0;
                w_alu_b = w_imm_u;
                w_we    = 1'b1;
            end
            OPC_AUIPC: begin
                w_alu_a = r_pc;
                w_alu_b = w_imm_u;
                w_we    = 1'b1;
            end
            OPC_JAL: begin
                w_we      = 1'b1;
                w_link    = 1'b1;
                w_next_pc = r_pc + w_imm_j;
            end
            OPC_JALR: begin
                if (w_f3 == 3'b000) begin
                    w_we      = 1'b1;
                    w_link    = 1'b1;
                    w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
                end
            end
            OPC_BRANCH: begin
                case (w_f3)
                    F3_BEQ:  w_take = w_eq;
                    F3_BNE:  w_take = !w_eq;
                    F3_BLT:  w_take = w_lt;
                    F3_BGE:  w_take = !w_lt;
                    F3_BLTU: w_take = w_ltu;
                    F3_BGEU: w_take = !w_ltu;
                    default: w_take = 1'b0;
                endcase
                if (w_take) w_next_pc = r_pc + w_imm_b;
            end
            default: ;
        endcase
    end

    // ALU: 32-bit wrap-around, shift amount from the low five bits.
    always_comb begin
        w_alu_y = '0;
        case (w_alu_op)
            ALU_ADD:  w_alu_y = w_alu_a + w_alu_b;
            ALU_SUB:  w_alu_y = w_alu_a - w_alu_b;
            ALU_SLL:  w_alu_y = w_alu_a << w_alu_b[4:0];
            ALU_SLT:  w_alu_y = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
            ALU_SLTU: w_alu_y = {31'd0, w_alu_a < w_alu_b};
            ALU_XOR:  w_alu_y = w_alu_a ^ w_alu_b;
            ALU_SRL:  w_alu_y = w_alu_a >> w_alu_b[4:0];
            ALU_SRA:  w_alu_y = $unsigned($signed(w_alu_a) >>> w_alu_b[4:0]);
            ALU_OR:   w_alu_y = w_alu_a | w_alu_b;
            ALU_AND:  w_alu_y = w_alu_a & w_alu_b;
            default:  w_alu_y = '0;
        endcase
    end

    // Retire one instruction per clock: PC and rd update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            r_pc <= w_next_pc;
            if (w_we && w_rd != 5'd0) r_regs[w_rd] <= w_wd;
        end
    end
endmodule

// File: rtl/riscv_soc_uart_rx.sv
// 8N1 UART receiver; emits a one-cycle byte_valid pulse per good frame.
//
// state   | meaning
// IDLE    | line idle, waiting for a falling edge
// START   | half-bit wait, confirm start bit still low
// DATA    | sample 8 data bits, LSB first
// STOP    | sample stop bit; accept byte only if high
module riscv_soc_uart_rx
    import riscv_pkg::*;
#(
    parameter int CPB = 5208
) (
    input logic         clk,
    input logic         rst_n,
    riscv_soc_if.master link
);
    localparam int CW = $clog2(CPB) + 1;
    localparam logic [CW-1:0] C_FULL = CW'(CPB - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CPB / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          r_sync1, r_sync2, r_prev;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_valid;
    logic          w_tick;

    assign w_tick          = (r_cnt == '0);
    assign link.byte_valid = r_valid;
    assign link.byte_data  = r_shift;

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= link.uart_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Frame FSM with a down-counting bit timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_prev && !r_sync2) begin
                        r_state <= S_START;
                        r_cnt   <= C_HALF;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_sync2) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DATA;
                            r_cnt   <= C_FULL;
                            r_bit   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_cnt   <= C_FULL;
                        if (r_bit == 3'd7) r_state <= S_STOP;
                        else               r_bit   <= r_bit + 3'd1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    if (w_tick) begin
                        r_valid <= r_sync2;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/riscv_soc_top.sv
// RV32I SoC: UART program loader into instruction RAM plus the core.
// Program RAM keeps its contents across rst_n.
module riscv_soc_top
    import riscv_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int IMEM_DEPTH = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic uart_rx,
    output logic uart_tx
);
    localparam int CPB     = clks_per_bit(CLK_FREQ, BAUD);
    localparam int IMEM_AW = $clog2(IMEM_DEPTH);

    riscv_soc_if u_link ();

    logic [1:0]         r_byte_cnt;
    logic [23:0]        r_word;
    logic [IMEM_AW-1:0] r_wr_ptr;
    logic [31:0]        r_imem [IMEM_DEPTH] = '{default: '0};
    logic [31:0]        w_word;
    logic               w_imem_we;
    logic [IMEM_AW-1:0] w_fetch_idx;
    logic [31:0]        w_instr;

    assign u_link.uart_rx = uart_rx;
    assign uart_tx        = 1'b1;
    assign w_word         = {r_word, u_link.byte_data};
    assign w_imem_we      = u_link.byte_valid && (r_byte_cnt == 2'd3);
    assign w_instr        = r_imem[w_fetch_idx];

    riscv_soc_uart_rx #(.CPB(CPB)) u_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (u_link)
    );

    riscv_core #(.IMEM_AW(IMEM_AW)) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_instr     (w_instr),
        .o_fetch_idx (w_fetch_idx)
    );

    // Word assembler: bytes arrive MSB first, every fourth one commits a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_wr_ptr   <= '0;
        end else if (u_link.byte_valid) begin
            r_word     <= w_word[23:0];
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_imem_we) r_wr_ptr <= r_wr_ptr + IMEM_AW'(1);
        end
    end

    // Instruction RAM write port; no reset so the program survives rst_n.
    always_ff @(posedge clk) begin
        if (w_imem_we) r_imem[r_wr_ptr] <= w_word;
    end
endmodule

// File: tb/tb_riscv_soc_top.sv
// Scoreboarded bench for riscv_soc_top: expected IMEM writes are queued as
// words are sent and popped when the loader commits them.
`timescale 1ns/1ps
module tb_riscv_soc_top;
    localparam int CLK_FREQ   = 6_400_000;
    localparam int BAUD       = 100_000;
    localparam int CPB        = 64;
    localparam int IMEM_DEPTH = 256;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_tx;
    int   checks = 0;
    int   failures = 0;
    int   n_bytes = 0;
    logic [7:0] last_byte = '0;
    logic [7:0] m_wr_ptr = '0;
    wr_t  sb [$];

    riscv_soc_if u_if ();

    riscv_soc_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .IMEM_DEPTH(IMEM_DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .uart_rx (u_if.uart_rx),
        .uart_tx (uart_tx)
    );

    assign u_if.byte_valid = dut.u_link.byte_valid;
    assign u_if.byte_data  = dut.u_link.byte_data;

    always #5 clk = ~clk;

    always @(negedge clk) begin : mon
        wr_t exp_wr;
        if (u_if.byte_valid) begin
            n_bytes++;
            last_byte = u_if.byte_data;
        end
        if (dut.w_imem_we) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL imem_write unexpected addr=%0d data=%h", dut.r_wr_ptr, dut.w_word);
            end else begin
                exp_wr = sb.pop_front();
                if (dut.r_wr_ptr !== exp_wr.addr || dut.w_word !== exp_wr.data) begin
                    failures++;
                    $display("FAIL imem_write got addr=%0d data=%h required addr=%0d data=%h",
                             dut.r_wr_ptr, dut.w_word, exp_wr.addr, exp_wr.data);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) u_if.uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            u_if.uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        u_if.uart_rx = stop;
        repeat (CPB) @(negedge clk);
        u_if.uart_rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        sb.push_back('{addr: m_wr_ptr, data: w});
        m_wr_ptr = m_wr_ptr + 8'd1;
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], 1'b1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 4 * CPB && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain pending=%0d required=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        m_wr_ptr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        u_if.uart_rx = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dut.u_core.r_pc !== 32'd0) begin
            failures++; $display("FAIL reset_pc got=%h required=0", dut.u_core.r_pc);
        end
        checks++;
        if (dut.r_wr_ptr !== 8'd0 || dut.r_byte_cnt !== 2'd0) begin
            failures++; $display("FAIL reset_loader got ptr=%0d cnt=%0d required 0/0", dut.r_wr_ptr, dut.r_byte_cnt);
        end
        checks++;
        if (dut.u_rx.r_state !== 2'd0 || uart_tx !== 1'b1) begin
            failures++; $display("FAIL reset_uart got state=%0d tx=%b required 0/1", dut.u_rx.r_state, uart_tx);
        end
        for (int r = 0; r < 32; r++) begin
            checks++;
            if (dut.u_core.r_regs[r] !== 32'd0) begin
                failures++; $display("FAIL reset_x%0d got=%h required=0", r, dut.u_core.r_regs[r]);
            end
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_download_run();
        logic [31:0] prog [4];
        logic [31:0] exp_pc [8];
        prog   = '{32'h00100093, 32'h00200113, 32'h001080B3, 32'hFE208EE3};
        exp_pc = '{32'h4, 32'h8, 32'hC, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18};
        for (int i = 0; i < 4; i++) send_word(prog[i]);
        wait_drain("download");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.r_imem[i] !== prog[i]) begin
                failures++; $display("FAIL imem%0d got=%h required=%h", i, dut.r_imem[i], prog[i]);
            end
        end
        do_reset();
        checks++;
        if (dut.u_core.r_pc !== 32'd0) begin
            failures++; $display("FAIL run_pc0 got=%h required=0", dut.u_core.r_pc);
        end
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            checks++;
            if (dut.u_core.r_pc !== exp_pc[s]) begin
                failures++; $display("FAIL run_pc step%0d got=%h required=%h", s + 1, dut.u_core.r_pc, exp_pc[s]);
            end
        end
        checks++;
        if (dut.u_core.r_regs[1] !== 32'd4 || dut.u_core.r_regs[2] !== 32'd2) begin
            failures++; $display("FAIL run_regs got x1=%h x2=%h required 4/2", dut.u_core.r_regs[1], dut.u_core.r_regs[2]);
        end
    endtask

    task automatic test_framing();
        int nb0;
        nb0 = n_bytes;
        send_byte(8'hA5, 1'b0);
        checks++;
        if ((n_bytes - nb0) !== 0 || dut.r_byte_cnt !== 2'd0) begin
            failures++; $display("FAIL framing_drop got bytes=%0d cnt=%0d required 0/0", n_bytes - nb0, dut.r_byte_cnt);
        end
        send_word(32'hCAFEBABE);
        wait_drain("framing");
        checks++;
        if ((n_bytes - nb0) !== 4 || last_byte !== 8'hBE) begin
            failures++; $display("FAIL framing_next got bytes=%0d last=%h required 4/be", n_bytes - nb0, last_byte);
        end
    endtask

    task automatic test_glitch();
        int nb0;
        nb0 = n_bytes;
        @(negedge clk) u_if.uart_rx = 1'b0;
        repeat (20) @(negedge clk);
        u_if.uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if ((n_bytes - nb0) !== 0 || dut.u_rx.r_state !== 2'd0) begin
            failures++; $display("FAIL glitch got bytes=%0d state=%0d required 0/0", n_bytes - nb0, dut.u_rx.r_state);
        end
    endtask

    task automatic test_reset_mid_word();
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        checks++;
        if (dut.r_byte_cnt !== 2'd2) begin
            failures++; $display("FAIL midword_cnt got=%0d required=2", dut.r_byte_cnt);
        end
        do_reset();
        send_word(32'h12345678);
        wait_drain("midword");
        checks++;
        if (dut.r_imem[0] !== 32'h12345678) begin
            failures++; $display("FAIL midword_imem0 got=%h required=12345678", dut.r_imem[0]);
        end
        checks++;
        if (dut.r_imem[1] !== 32'h00200113 || dut.r_imem[2] !== 32'h001080B3 || dut.r_imem[3] !== 32'hFE208EE3) begin
            failures++; $display("FAIL midword_keep got %h %h %h required 00200113 001080b3 fe208ee3",
                                 dut.r_imem[1], dut.r_imem[2], dut.r_imem[3]);
        end
    endtask

    task automatic test_alu_branch();
        logic [31:0] prog [5];
        prog = '{32'hFFF00193, 32'h01C1D213, 32'h41C1D293, 32'h00303333, 32'h0001E463};
        do_reset();
        for (int i = 0; i < 5; i++) send_word(prog[i]);
        wait_drain("alu");
        do_reset();
        repeat (5) @(negedge clk);
        checks++;
        if (dut.u_core.r_pc !== 32'h14) begin
            failures++; $display("FAIL alu_bltu_pc got=%h required=14", dut.u_core.r_pc);
        end
        checks++;
        if (dut.u_core.r_regs[3] !== 32'hFFFFFFFF || dut.u_core.r_regs[4] !== 32'hF) begin
            failures++; $display("FAIL alu_srli got x3=%h x4=%h required ffffffff/f", dut.u_core.r_regs[3], dut.u_core.r_regs[4]);
        end
        checks++;
        if (dut.u_core.r_regs[5] !== 32'hFFFFFFFF || dut.u_core.r_regs[6] !== 32'd1) begin
            failures++; $display("FAIL alu_srai_sltu got x5=%h x6=%h required ffffffff/1", dut.u_core.r_regs[5], dut.u_core.r_regs[6]);
        end
    endtask

    task automatic test_jal_x0();
        do_reset();
        send_word(32'h0080006F);
        send_word(32'h00700093);
        send_word(32'h00500013);
        wait_drain("jal");
        do_reset();
        @(negedge clk);
        checks++;
        if (dut.u_core.r_pc !== 32'h8) begin
            failures++; $display("FAIL jal_pc got=%h required=8", dut.u_core.r_pc);
        end
        @(negedge clk);
        checks++;
        if (dut.u_core.r_pc !== 32'hC) begin
            failures++; $display("FAIL jal_next_pc got=%h required=c", dut.u_core.r_pc);
        end
        checks++;
        if (dut.u_core.r_regs[0] !== 32'd0 || dut.u_core.r_regs[1] !== 32'd0) begin
            failures++; $display("FAIL jal_x0 got x0=%h x1=%h required 0/0", dut.u_core.r_regs[0], dut.u_core.r_regs[1]);
        end
    endtask

    initial begin
        test_reset();
        test_download_run();
        test_framing();
        test_glitch();
        test_reset_mid_word();
        test_alu_branch();
        test_jal_x0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
